// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM
// state enums, NZCV bit positions and a flag-packing helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flags reported for an opcode the build does not implement: N=0 Z=1 C=0 V=1.
  localparam logic [3:0] FLAGS_UNSUPPORTED = 4'b0101;

  // Place individual flag bits at their NZCV positions.
  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// LSB first, W iterations after start. done pulses for one cycle once
// product holds the full 2W-bit result.
module alu_mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Next-state: load on start, otherwise add the shifted multiplicand when
  // the current multiplier bit is set and advance one bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any partial product.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: ADD/SUB/AND/OR/XOR/LSL/LSR complete one cycle
// after accept; MUL iterates in alu_mul_iter when ALU_SEQ_MUL_EN is
// defined, otherwise it completes at once as an unsupported op (y=0,
// flags 0101). NZCV is committed only on retire of a set_flags op.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ALUControl,
  input  logic         set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [3:0]   flags
);

  alu_state_t state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [3:0]   pend_q, pend_d;   // NZCV of the op in flight, committed on retire
  logic         setf_q, setf_d;
  logic [3:0]   flags_q, flags_d;

  alu_op_t      op_in;
  logic [SHW-1:0] sh;
  logic [W-1:0] b_eff;
  logic [W:0]   add_ext;
  logic [W:0]   lsl_ext;
  logic [W:0]   lsr_ext;
  logic [W-1:0] dp_y;
  logic         dp_c;
  logic         dp_v;
  logic [3:0]   dp_flags;
  logic         accept;
  logic         mul_start;

  assign op_in  = alu_op_t'(ALUControl);
  assign sh     = b[SHW-1:0];
  assign accept = (state_q == ST_IDLE) && in_valid;

  // Single-cycle datapath on the live operands; its result is captured at accept.
  // The extra bit of each extended shift catches the last bit shifted out.
  always_comb begin
    dp_y    = '0;
    dp_c    = 1'b0;
    dp_v    = 1'b0;
    b_eff   = (op_in == OP_SUB) ? ~b : b;
    add_ext = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, (op_in == OP_SUB)};
    lsl_ext = {1'b0, a} << sh;
    lsr_ext = {a, 1'b0} >> sh;
    case (op_in)
      OP_ADD, OP_SUB: begin
        dp_y = add_ext[W-1:0];
        dp_c = add_ext[W];
        dp_v = (a[W-1] == b_eff[W-1]) && (add_ext[W-1] != a[W-1]);
      end
      OP_AND: dp_y = a & b;
      OP_OR:  dp_y = a | b;
      OP_XOR: dp_y = a ^ b;
      OP_LSL: begin
        dp_y = lsl_ext[W-1:0];
        dp_c = lsl_ext[W];
      end
      OP_LSR: begin
        dp_y = lsr_ext[W:1];
        dp_c = lsr_ext[0];
      end
      default: begin
        dp_y = '0;
      end
    endcase
  end

  assign dp_flags = pack_nzcv(dp_y[W-1], (dp_y == '0), dp_c, dp_v);

`ifdef ALU_SEQ_MUL_EN
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic           mul_hi;

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_hi = |mul_prod[2*W-1:W];
`endif

  // FSM next-state and register next values.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    pend_d    = pend_q;
    setf_d    = setf_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          setf_d = set_flags;
          if (op_in == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
            mul_start = 1'b1;
            state_d   = ST_BUSY;
`else
            y_d     = '0;
            pend_d  = FLAGS_UNSUPPORTED;
            state_d = ST_DONE;
`endif
          end else begin
            y_d     = dp_y;
            pend_d  = dp_flags;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          y_d     = mul_prod[W-1:0];
          pend_d  = pack_nzcv(mul_prod[W-1], (mul_prod[W-1:0] == '0), mul_hi, mul_hi);
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          if (setf_q) begin
            flags_d = pend_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      pend_q  <= '0;
      setf_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      setf_q  <= setf_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed vector table, reset
// mid-operation, then randomized ops against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   ALUControl;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] model_flags;

  alu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .set_flags  (set_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       setf;
    int         hold;
    logic [7:0] exp_y;
    logic [3:0] exp_flags;  // flag register after retire
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model from the arithmetic definitions; returns {y, NZCV}.
  function automatic logic [11:0] ref_model(input int ua, input int ub, input int op);
    int sa, sb, s, ss, sh, yv, c, v;
    logic [7:0] yr;
    logic [3:0] f;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sh = ub % 8;
    c = 0; v = 0; yv = 0;
    case (op)
      0: begin s = ua + ub; yv = s % 256; c = (s > 255); ss = sa + sb; v = (ss > 127 || ss < -128); end
      1: begin s = ua + (255 - ub) + 1; yv = s % 256; c = (s > 255); ss = sa - sb; v = (ss > 127 || ss < -128); end
      2: yv = ua & ub;
      3: yv = ua | ub;
      4: yv = ua ^ ub;
      5: begin yv = (ua * (1 << sh)) % 256; c = (sh == 0) ? 0 : ((ua >> (8 - sh)) & 1); end
      6: begin yv = ua >> sh; c = (sh == 0) ? 0 : ((ua >> (sh - 1)) & 1); end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        s = ua * ub; yv = s % 256; c = (s > 255); v = c;
`else
        yr = 8'h00;
        return {yr, 4'b0101};
`endif
      end
    endcase
    yr = yv[7:0];
    f  = {yr[7], (yr == 8'h00), c[0], v[0]};
    return {yr, f};
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op == 3'b111) ? W + 1 : 1;
`else
    return 1;
`endif
  endfunction

  // Issue one op at a negedge, check latency/result/hold behaviour and the
  // flag register around retire.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] op,
                        input logic ts, input int hold, input logic [7:0] ey,
                        input logic [3:0] ef_after, input string nm);
    int lat;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({nm, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a = ta; b = tb_; ALUControl = op; set_flags = ts;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); set_flags = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, exp_latency(op));
    check({nm, "_y"}, y, ey);
    check({nm, "_flags_pre"}, flags, model_flags);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); ALUControl = 3'($urandom);
      @(negedge clk);
      check({nm, "_hold_y"}, y, ey);
      check({nm, "_hold_valid"}, out_valid, 1'b1);
      check({nm, "_hold_ready"}, in_ready, 1'b0);
      check({nm, "_hold_flags"}, flags, model_flags);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    model_flags = ef_after;
    check({nm, "_flags_post"}, flags, model_flags);
    check({nm, "_retired"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [11:0] r;
    logic [7:0]  ra, rb;
    logic [2:0]  rop;
    logic        rs;

    // {a, b, op, set_flags, hold, expected y, expected flags after retire}
    vecs[0]  = '{8'h7F, 8'h01, 3'b000, 1'b1, 5, 8'h80, 4'b1001};
    vecs[1]  = '{8'h05, 8'h05, 3'b001, 1'b1, 0, 8'h00, 4'b0110};
    vecs[2]  = '{8'hF0, 8'h0F, 3'b010, 1'b0, 0, 8'h00, 4'b0110};
    vecs[3]  = '{8'h81, 8'h01, 3'b101, 1'b1, 0, 8'h02, 4'b0010};
    vecs[4]  = '{8'h01, 8'h09, 3'b110, 1'b1, 0, 8'h00, 4'b0110};
    vecs[5]  = '{8'h00, 8'h01, 3'b001, 1'b1, 0, 8'hFF, 4'b1000};
    vecs[6]  = '{8'h80, 8'h01, 3'b011, 1'b1, 0, 8'h81, 4'b1000};
    vecs[7]  = '{8'hFF, 8'hFF, 3'b100, 1'b1, 0, 8'h00, 4'b0100};
    vecs[8]  = '{8'h80, 8'h80, 3'b000, 1'b1, 0, 8'h00, 4'b0111};
`ifdef ALU_SEQ_MUL_EN
    vecs[9]  = '{8'h10, 8'h11, 3'b111, 1'b1, 5, 8'h10, 4'b0011};
    vecs[10] = '{8'h03, 8'h05, 3'b111, 1'b1, 0, 8'h0F, 4'b0000};
`else
    vecs[9]  = '{8'h10, 8'h11, 3'b111, 1'b0, 5, 8'h00, 4'b0111};
    vecs[10] = '{8'h03, 8'h05, 3'b111, 1'b1, 0, 8'h00, 4'b0101};
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ALUControl = '0; set_flags = 1'b0;
    model_flags = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {in_ready, out_valid, y, flags}, {1'b1, 1'b0, 8'h00, 4'h0});

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].setf, vecs[i].hold,
             vecs[i].exp_y, vecs[i].exp_flags, $sformatf("vec%0d", i));
    end

    // Make flags nonzero, then reset four cycles into a MUL.
    run_op(8'h7F, 8'h01, 3'b000, 1'b1, 0, 8'h80, 4'b1001, "pre_reset_add");
    in_valid = 1'b1; a = 8'h10; b = 8'h11; ALUControl = 3'b111; set_flags = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_flags = 4'b0000;
    check("midmul_reset", {out_valid, in_ready, y, flags}, {1'b1 ^ 1'b1, 1'b1, 8'h00, 4'h0});
    repeat (12) @(negedge clk);
    check("midmul_discard", {out_valid, in_ready, flags}, {1'b0, 1'b1, 4'h0});

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom);
      rs  = 1'($urandom);
      r   = ref_model(int'(ra), int'(rb), int'(rop));
      run_op(ra, rb, rop, rs, int'($urandom_range(0, 2)), r[11:4],
             rs ? r[3:0] : model_flags, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
